// File: rtl/calib_pkg.sv
// calib_pkg: widths, coefficient address map and FSM encoding shared by the calibration sequencer.
package calib_pkg;
    localparam int ADC_W     = 12;
    localparam int ADC_SHIFT = 5;
    localparam int GAIN_W    = 13;
    localparam int DATA_W    = 38;
    localparam int PROD_W    = GAIN_W + DATA_W;

    localparam logic [2:0] A_OFF0 = 3'd3;
    localparam logic [2:0] A_END  = 3'd6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef logic signed [GAIN_W-1:0] gain_t;
    typedef logic signed [DATA_W-1:0] data_t;

    function automatic data_t align(input logic [ADC_W-1:0] raw);
        return {{(DATA_W-ADC_W-ADC_SHIFT){1'b0}}, raw, {ADC_SHIFT{1'b0}}};
    endfunction
endpackage

// File: rtl/calib_mac.sv
// calib_mac: registered signed gain*x product followed by a truncating offset add.
module calib_mac import calib_pkg::*; (
    input  logic  clk,
    input  logic  rst,
    input  gain_t gain,
    input  data_t x,
    input  data_t offset,
    input  logic  mul_en,
    input  logic  add_en,
    output data_t sum
);
    logic signed [PROD_W-1:0] prod;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            prod <= '0;
        else if (mul_en)
            prod <= gain * x;

    assign sum = add_en ? prod[DATA_W-1:0] + offset : '0;
endmodule

// File: rtl/calib_sequencer.sv
// calib_sequencer: time-multiplexes gain/offset calibration of three ADC channels over one MAC
// and owns the shadow/active coefficient banks.
module calib_sequencer import calib_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              CE,
    input  logic [ADC_W-1:0]  Iref,
    input  logic [ADC_W-1:0]  Vdc1,
    input  logic [ADC_W-1:0]  Vdc2,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_commit,
    input  logic              overrun_clr,
    output data_t             Iref_adap,
    output data_t             Vdc1_adap,
    output data_t             Vdc2_adap,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              commit_pending
);
    logic [1:0]       state, ch, oi;
    logic [ADC_W-1:0] cap [3];
    gain_t            g_sh [3], g_act [3];
    data_t            o_sh [3], o_act [3], stage [3];
    data_t            x, sum;
    logic             idle, done, apply;

    assign idle  = state == S_IDLE;
    assign done  = state == S_DONE;
    assign busy  = !idle;
    // Commits land only between conversions, so a result never mixes coefficient sets.
    assign apply = (idle && cfg_commit) || (done && (commit_pending || cfg_commit));
    assign x     = align(cap[ch]);
    assign oi    = cfg_addr[1:0] + 2'd1;

    calib_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .gain   (g_act[ch]),
        .x      (x),
        .offset (o_act[ch]),
        .mul_en (state == S_MUL),
        .add_en (state == S_ADD),
        .sum    (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            ch             <= '0;
            Iref_adap      <= '0;
            Vdc1_adap      <= '0;
            Vdc2_adap      <= '0;
            out_valid      <= 1'b0;
            overrun        <= 1'b0;
            commit_pending <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cap[i]   <= '0;
                g_sh[i]  <= '0;
                g_act[i] <= '0;
                o_sh[i]  <= '0;
                o_act[i] <= '0;
                stage[i] <= '0;
            end
        end else begin
            out_valid      <= done;
            overrun        <= (CE && !idle) || (overrun && !overrun_clr);
            commit_pending <= !idle && !done && (commit_pending || cfg_commit);
            if (cfg_we && cfg_addr < A_OFF0)
                g_sh[cfg_addr[1:0]] <= cfg_data[GAIN_W-1:0];
            else if (cfg_we && cfg_addr < A_END)
                o_sh[oi] <= cfg_data;
            if (apply) begin
                g_act <= g_sh;
                o_act <= o_sh;
            end
            case (state)
                S_IDLE: if (CE) begin
                    cap[0] <= Iref;
                    cap[1] <= Vdc1;
                    cap[2] <= Vdc2;
                    ch     <= '0;
                    state  <= S_MUL;
                end
                S_MUL: state <= S_ADD;
                S_ADD: begin
                    stage[ch] <= sum;
                    ch        <= ch == 2'd2 ? ch : ch + 2'd1;
                    state     <= ch == 2'd2 ? S_DONE : S_MUL;
                end
                default: begin
                    Iref_adap <= stage[0];
                    Vdc1_adap <= stage[1];
                    Vdc2_adap <= stage[2];
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calib_sequencer.sv
// tb_calib_sequencer: directed stimulus with a transaction-level reference model checked every cycle.
module tb_calib_sequencer;
    logic clk = 1'b0, rst = 1'b1, CE = 1'b0, cfg_we = 1'b0, cfg_commit = 1'b0, overrun_clr = 1'b0;
    logic [11:0] Iref = '0, Vdc1 = '0, Vdc2 = '0;
    logic [2:0]  cfg_addr = '0;
    logic [37:0] cfg_data = '0;
    logic signed [37:0] Iref_adap, Vdc1_adap, Vdc2_adap;
    logic out_valid, busy, overrun, commit_pending;
    int n_chk = 0, n_fail = 0, lat;

    calib_sequencer dut (
        .clk(clk), .rst(rst), .CE(CE), .Iref(Iref), .Vdc1(Vdc1), .Vdc2(Vdc2),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .overrun_clr(overrun_clr), .Iref_adap(Iref_adap), .Vdc1_adap(Vdc1_adap),
        .Vdc2_adap(Vdc2_adap), .out_valid(out_valid), .busy(busy), .overrun(overrun),
        .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Result = (gain * raw * 32 + offset) modulo 2^38, read back as signed.
    function automatic logic signed [37:0] calc(input logic signed [12:0] g, input logic [11:0] r,
                                                input logic signed [37:0] o);
        longint v;
        v = longint'(g) * longint'(r) * 32 + longint'(o);
        return v[37:0];
    endfunction

    // Model: a conversion is a 7-cycle window counted from the accepting edge.
    logic signed [12:0] m_sg [3], m_ag [3];
    logic signed [37:0] m_so [3], m_ao [3], m_out [3];
    logic [11:0]        m_cap [3];
    int                 m_cnt;
    logic               m_valid, m_ovr, m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_sg[i] <= '0; m_ag[i] <= '0; m_so[i] <= '0; m_ao[i] <= '0;
                m_out[i] <= '0; m_cap[i] <= '0;
            end
            m_cnt <= 0; m_valid <= 1'b0; m_ovr <= 1'b0; m_pend <= 1'b0;
        end else begin
            m_valid <= m_cnt == 7;
            if (CE && m_cnt != 0) m_ovr <= 1'b1;
            else if (overrun_clr) m_ovr <= 1'b0;
            if (cfg_we && int'(cfg_addr) < 3) m_sg[int'(cfg_addr)] <= cfg_data[12:0];
            else if (cfg_we && int'(cfg_addr) < 6) m_so[int'(cfg_addr) - 3] <= cfg_data;
            if (m_cnt == 0) begin
                if (cfg_commit) begin m_ag <= m_sg; m_ao <= m_so; end
                if (CE) begin
                    m_cap[0] <= Iref; m_cap[1] <= Vdc1; m_cap[2] <= Vdc2; m_cnt <= 1;
                end
            end else if (m_cnt == 7) begin
                for (int i = 0; i < 3; i++) m_out[i] <= calc(m_ag[i], m_cap[i], m_ao[i]);
                if (m_pend || cfg_commit) begin m_ag <= m_sg; m_ao <= m_so; end
                m_pend <= 1'b0;
                m_cnt  <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (cfg_commit) m_pend <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("Iref_adap", Iref_adap, m_out[0]);
        check("Vdc1_adap", Vdc1_adap, m_out[1]);
        check("Vdc2_adap", Vdc2_adap, m_out[2]);
        check("out_valid", out_valid, m_valid);
        check("busy", busy, m_cnt != 0);
        check("overrun", overrun, m_ovr);
        check("commit_pending", commit_pending, m_pend);
    end

    task automatic wr(input logic [2:0] a, input logic [37:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic conv(input logic [11:0] i, input logic [11:0] v1, input logic [11:0] v2);
        Iref = i; Vdc1 = v1; Vdc2 = v2; CE = 1'b1;
        @(negedge clk);
        CE = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (out_valid !== 1'b1 && l < 15) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_Iref", Iref_adap, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        wr(0, 2); wr(1, 1); wr(2, 1); wr(3, 10);
        commit();
        conv(100, 200, 300);
        check("basic_busy", busy, 1);
        wait_valid(lat);
        check("basic_lat", lat, 7);
        check("basic_Iref", Iref_adap, 6410);
        check("basic_Vdc1", Vdc1_adap, 6400);
        check("basic_Vdc2", Vdc2_adap, 9600);
        check("basic_busy_done", busy, 0);
        @(negedge clk);
        check("basic_pulse", out_valid, 0);

        wr(1, -38'sd3);
        commit();
        conv(100, 4095, 300);
        wait_valid(lat);
        check("neg_Vdc1", Vdc1_adap, -393120);
        check("neg_Iref", Iref_adap, 6410);
        check("neg_Vdc2", Vdc2_adap, 9600);

        conv(1, 1, 1);
        repeat (2) @(negedge clk);
        conv(2, 2, 2);
        check("ovr_set", overrun, 1);
        wait_valid(lat);
        check("ovr_lat", lat, 4);
        check("ovr_Iref", Iref_adap, 74);
        repeat (3) @(negedge clk);
        check("ovr_sticky", overrun, 1);
        conv(3, 3, 3);
        CE = 1'b1; overrun_clr = 1'b1;
        @(negedge clk);
        CE = 1'b0; overrun_clr = 1'b0;
        check("ovr_set_wins", overrun, 1);
        wait_valid(lat);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        conv(5, 0, 0);
        wait_valid(lat);
        conv(6, 0, 0);
        check("b2b_busy", busy, 1);
        wait_valid(lat);
        check("b2b_lat", lat, 7);
        check("b2b_Iref", Iref_adap, 394);
        check("b2b_overrun", overrun, 0);

        wr(0, 5);
        conv(100, 0, 0);
        @(negedge clk);
        commit();
        check("pend_set", commit_pending, 1);
        commit();
        wait_valid(lat);
        check("pend_old_gain", Iref_adap, 6410);
        check("pend_clear", commit_pending, 0);
        conv(100, 0, 0);
        wait_valid(lat);
        check("pend_new_gain", Iref_adap, 16010);

        conv(100, 100, 100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_Iref", Iref_adap, 0);
        check("abort_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        conv(100, 4095, 4095);
        wait_valid(lat);
        check("post_rst_lat", lat, 7);
        check("post_rst_Iref", Iref_adap, 0);
        check("post_rst_Vdc2", Vdc2_adap, 0);

        wr(2, 4095);
        wr(5, 38'h1F_FFFF_FFFF);
        commit();
        conv(0, 0, 4095);
        wait_valid(lat);
        check("max_Vdc2", Vdc2_adap, -64'sd136902344673);
        check("max_Iref", Iref_adap, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end
endmodule
